bus_responder: RTL
==================

# bus_responder

Memory-side responder for the core's byte bus. It samples the core's 20-bit address, write strobe and write data, and serves each access from external 8-bit asynchronous SRAM, an internal synchronous BIOS ROM, or an unmapped hole. It stalls the core through the core's `locked` enable until the access is complete. It sits between `core` and the board memory, and its `locked` output drives the core's `locked` input directly.

## Interface
- WAIT_STATES, 2: number of cycles the SRAM OE/WE strobe is held low; legal range 1–15.
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  20  core physical address.
- we  in  1  core write request for the current address.
- out  in  8  core write data.
- in  out  8  read data to the core; registered.
- locked  out  1  core enable; high for exactly one cycle per completed access.
- rom_addr  out  16  BIOS ROM address; registered.
- rom_q  in  8  BIOS ROM data; valid one clock after rom_addr is registered.
- sram_a  out  19  SRAM address.
- sram_d_in  in  8  SRAM read data.
- sram_d_out  out  8  SRAM write data.
- sram_d_oe  out  1  enables the SRAM data pad driver.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.

## Operation
- Address map, decoded on the address latched in IDLE:
  - 00000–7FFFF: SRAM, with sram_a = addr[18:0].
  - 80000–EFFFF: unmapped. Reads return FFh; writes are dropped.
  - F0000–FFFFF: ROM, with rom_addr = addr[15:0]. Writes are dropped.
- States:
  - IDLE: latch address, we and out into addr_q, we_q and data_q. Go to the next state by region:
    - SRAM read → RD.
    - SRAM write → WS.
    - ROM read → R1.
    - Unmapped read → ACK, with in <= FFh.
    - Dropped write → ACK.
  - RD: sram_oe_n=0 and sram_a=addr_q for WAIT_STATES cycles. On the last cycle, in <= sram_d_in, then → ACK.
  - WS (setup, 1 cycle): sram_a valid, sram_d_out=data_q, sram_d_oe=1, sram_we_n=1. → WP.
  - WP: sram_we_n=0 for WAIT_STATES cycles; address and data held. → WH.
  - WH (hold, 1 cycle): sram_we_n=1, sram_d_oe=1, address and data held. → ACK.
  - R1: the ROM registers rom_addr. → R2.
  - R2: in <= rom_q. → ACK.
  - ACK: locked=1 for this cycle only. → IDLE.
- For all writes (SRAM, ROM, unmapped), in <= data_q, so the written byte is echoed back.
- locked is 0 in every state except ACK. The core advances only on the ACK edge, so it holds address, we and out stable for the whole transaction.
- The block never drives SRAM OE and WE low in the same cycle. sram_d_oe is 0 whenever sram_oe_n is 0.
- The WAIT_STATES counter is 4 bits wide. It loads WAIT_STATES-1 on entry to RD or WP and the state exits on count 0.

## Timing
- Reset values: in=FFh, locked=0, sram_oe_n=1, sram_we_n=1, sram_d_oe=0, sram_a=0, sram_d_out=0, rom_addr=0. State goes to IDLE.
- Reset asserted mid-transaction: on the next edge the block returns to IDLE, all strobes are released, no ACK is issued and no partial write completes beyond that edge.
- Cycles from IDLE entry to the end of the ACK cycle:
  - SRAM read: WAIT_STATES+2.
  - SRAM write: WAIT_STATES+4.
  - ROM read: 4.
  - Unmapped or dropped write: 2.
- `in` is stable from the edge entering ACK until the next load.
- Back-to-back transactions: the cycle after ACK is IDLE, which re-samples the address the core presents after its step.
- All outputs are registered; none are combinational from address.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → in=FFh, locked=0, sram_oe_n=1, sram_we_n=1, sram_d_oe=0.
- ROM read: address=FFFF0, rom_q model returns EAh → rom_addr=FFF0, locked pulses 1 cycle on cycle 4, in=EAh.
- SRAM write then read, WAIT_STATES=2:
  - Write 5Ah to 12345 → sram_a=12345, we_n low exactly 2 cycles bracketed by 1 setup and 1 hold cycle with d_oe=1, locked on cycle 6.
  - Read back 12345 → oe_n low 2 cycles, in=5Ah, locked on cycle 4.
- Boundaries:
  - Read 7FFFF → goes to SRAM.
  - Read 80000 → in=FFh, locked on cycle 2, no SRAM strobe.
  - Read EFFFF → in=FFh.
  - Write to F0000 → no strobe on the SRAM or ROM path, locked on cycle 2.
- Reset during WP: assert reset_n=0 on the first WP cycle → sram_we_n=1 and sram_d_oe=0 after the next edge, locked never asserts, state is IDLE.
- WAIT_STATES=1 and WAIT_STATES=15 builds: SRAM read completes on cycle 3 and cycle 17 respectively; OE and WE are never low simultaneously (checked by assertion).

Source files
------------

// File: rtl/bus_responder.sv
// Memory-side responder for the core byte bus. Decodes each access to the
// external asynchronous SRAM, the synchronous BIOS ROM or the unmapped hole,
// and holds the core stalled until the one-cycle locked pulse in ACK.
//
// state | meaning
// IDLE  | sample address/we/out, decode region, pick the access path
// RD    | SRAM read, OE low for WAIT_STATES cycles, data captured on the last
// WS    | SRAM write setup, data driven, WE still high
// WP    | SRAM write pulse, WE low for WAIT_STATES cycles
// WH    | SRAM write hold, WE high, data still driven
// R1    | ROM registers rom_addr
// R2    | ROM data captured into in
// ACK   | locked high for one cycle, core advances
module bus_responder #(
   parameter int WAIT_STATES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [19:0] address,
   input  logic        we,
   input  logic [7:0]  out,
   output logic [7:0]  in,
   output logic        locked,
   output logic [15:0] rom_addr,
   input  logic [7:0]  rom_q,
   output logic [18:0] sram_a,
   input  logic [7:0]  sram_d_in,
   output logic [7:0]  sram_d_out,
   output logic        sram_d_oe,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {IDLE, RD, WS, WP, WH, R1, R2, ACK} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [7:0]  data_q, data_next;
   logic [7:0]  in_next;
   logic [7:0]  sram_d_out_next;
   logic [18:0] sram_a_next;
   logic [15:0] rom_addr_next;
   logic        region_sram;
   logic        region_rom;

   // Region decode on the live core address; only consulted in IDLE, where
   // the core is guaranteed to hold it stable.
   always_comb begin
      region_sram = ~address[19];
      region_rom  = (address[19:16] == 4'hF);
   end

   // Next-state, wait counter and next values of the registered outputs.
   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      data_next       = data_q;
      in_next         = in;
      sram_a_next     = sram_a;
      sram_d_out_next = sram_d_out;
      rom_addr_next   = rom_addr;
      case (state)
         IDLE: begin
            data_next = out;
            if (region_sram) begin
               sram_a_next = address[18:0];
               if (we) begin
                  sram_d_out_next = out;
                  state_next      = WS;
               end else begin
                  cnt_next   = WAIT_LOAD;
                  state_next = RD;
               end
            end else if (we) begin
               // ROM and unmapped writes are dropped but still echoed.
               in_next    = out;
               state_next = ACK;
            end else if (region_rom) begin
               rom_addr_next = address[15:0];
               state_next    = R1;
            end else begin
               in_next    = 8'hFF;
               state_next = ACK;
            end
         end
         RD: begin
            if (cnt == 4'd0) begin
               in_next    = sram_d_in;
               state_next = ACK;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         WS: begin
            cnt_next   = WAIT_LOAD;
            state_next = WP;
         end
         WP: begin
            if (cnt == 4'd0) begin
               state_next = WH;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         WH: begin
            in_next    = data_q;
            state_next = ACK;
         end
         R1:      state_next = R2;
         R2: begin
            in_next    = rom_q;
            state_next = ACK;
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State and output registers; strobes are decoded from the next state so
   // they line up with the state they belong to and never glitch.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         data_q     <= 8'd0;
         in         <= 8'hFF;
         locked     <= 1'b0;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_d_oe  <= 1'b0;
         sram_a     <= 19'd0;
         sram_d_out <= 8'd0;
         rom_addr   <= 16'd0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         data_q     <= data_next;
         in         <= in_next;
         locked     <= (state_next == ACK);
         sram_oe_n  <= (state_next != RD);
         sram_we_n  <= (state_next != WP);
         sram_d_oe  <= (state_next == WS) || (state_next == WP) || (state_next == WH);
         sram_a     <= sram_a_next;
         sram_d_out <= sram_d_out_next;
         rom_addr   <= rom_addr_next;
      end
   end

endmodule
